// File: rtl/img_pkg.sv
// Shared image-pipeline constants and types for the row assembly front end.
package img_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned ROW_LEN      = 8;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned ROWS_PER_BLK = 8;
    localparam int unsigned ROW_W        = PIX_W * ROW_LEN;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/pixel_row_assembler_col_counter.sv
// Wrap counter with enable and synchronous active-low clear; wraps after WRAP counts.
module col_counter
    import img_pkg::*;
#(
    parameter int unsigned CNT_W = img_pkg::CNT_W,
    parameter int unsigned WRAP  = 1 << CNT_W
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == CNT_W'(WRAP - 1)) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pixel_row_assembler.sv
// Packs 8 accepted pixels into a row word using two ping-pong banks so input
// keeps flowing while downstream stalls; each row carries its index in the block.
module pixel_row_assembler
    import img_pkg::*;
#(
    parameter int unsigned PIX_W        = img_pkg::PIX_W,
    parameter int unsigned ROW_LEN      = img_pkg::ROW_LEN,
    parameter int unsigned CNT_W        = img_pkg::CNT_W,
    parameter int unsigned ROWS_PER_BLK = img_pkg::ROWS_PER_BLK
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic [PIX_W*ROW_LEN-1:0] row_out,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [CNT_W-1:0]         row_idx,
    output logic                     blk_last,
    output logic [CNT_W-1:0]         col_cnt
);

    localparam int unsigned RW = PIX_W * ROW_LEN;

    logic [RW-1:0]    r_bank [2];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;

    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_row_done;
    logic [CNT_W-1:0] w_col_cnt;
    logic [CNT_W-1:0] w_row_idx;

    assign pix_ready  = !r_full[r_wr_bank];
    assign row_valid  = r_full[r_rd_bank];
    assign row_out    = r_bank[r_rd_bank];
    assign w_wr_fire  = pix_valid && pix_ready;
    assign w_rd_fire  = row_valid && row_ready;
    assign w_row_done = w_wr_fire && (w_col_cnt == CNT_W'(ROW_LEN - 1));

    col_counter #(.CNT_W(CNT_W), .WRAP(ROW_LEN)) u_col_cnt (
        .clk     (clk),
        .i_clr_n (rst),
        .i_en    (w_wr_fire),
        .o_cnt   (w_col_cnt)
    );

    col_counter #(.CNT_W(CNT_W), .WRAP(ROWS_PER_BLK)) u_row_idx (
        .clk     (clk),
        .i_clr_n (rst),
        .i_en    (w_rd_fire),
        .o_cnt   (w_row_idx)
    );

    // A completing fill always targets an empty bank and a drain a full one,
    // so the two flag updates below never touch the same bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_bank[r_wr_bank][w_col_cnt*PIX_W +: PIX_W] <= pix_in;
            end
            if (w_row_done) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_rd_fire) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    assign row_idx  = w_row_idx;
    assign col_cnt  = w_col_cnt;
    assign blk_last = row_valid && (w_row_idx == CNT_W'(ROWS_PER_BLK - 1));

endmodule

// File: tb/tb_pixel_row_assembler.sv
// Scoreboard bench for pixel_row_assembler: rows are predicted from accepted pixels.
module tb_pixel_row_assembler;
    import img_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [63:0] row_out;
    logic        row_valid;
    logic        row_ready = 1'b0;
    logic [2:0]  row_idx;
    logic        blk_last;
    logic [2:0]  col_cnt;

    always #5 clk = ~clk;

    pixel_row_assembler #(
        .PIX_W(8), .ROW_LEN(8), .CNT_W(3), .ROWS_PER_BLK(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .row_out   (row_out),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_idx   (row_idx),
        .blk_last  (blk_last),
        .col_cnt   (col_cnt)
    );

    typedef struct {
        logic [63:0] row;
        logic [2:0]  idx;
    } exp_t;

    exp_t        q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        checking = 1'b0;
    logic [63:0] mdl_row = '0;
    logic [2:0]  mdl_col = '0;
    logic [2:0]  mdl_wr_idx = '0;
    logic [2:0]  mdl_rd_idx = '0;
    int unsigned accepted = 0;
    int unsigned drained = 0;
    int unsigned stall_cnt = 0;
    int unsigned blk_cnt = 0;
    logic        t4_phase = 1'b0;
    logic        rand_rr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: compare DUT state with the model, then advance the model by the
    // handshakes that the coming posedge will see.
    always @(negedge clk) begin
        logic do_drain;
        logic do_acc;
        exp_t e;
        if (checking) begin
            chk("row_valid", row_valid, q.size() > 0);
            chk("pix_ready", pix_ready, q.size() < 2);
            chk("col_cnt", col_cnt, mdl_col);
            chk("row_idx", row_idx, mdl_rd_idx);
            chk("blk_last", blk_last, (q.size() > 0) && (mdl_rd_idx == 3'd7));
            if (q.size() > 0) chk("row_out", row_out, q[0].row);
        end
        if (!rst) begin
            q.delete();
            mdl_row    = '0;
            mdl_col    = '0;
            mdl_wr_idx = '0;
            mdl_rd_idx = '0;
            checking   = 1'b1;
        end else begin
            do_drain = (q.size() > 0) && row_ready;
            do_acc   = pix_valid && (q.size() < 2);
            if (t4_phase && pix_valid && !do_acc) stall_cnt++;
            if (do_drain) begin
                if (mdl_rd_idx == 3'd7) blk_cnt++;
                void'(q.pop_front());
                drained++;
                mdl_rd_idx++;
            end
            if (do_acc) begin
                mdl_row[mdl_col*8 +: 8] = pix_in;
                accepted++;
                if (mdl_col == 3'd7) begin
                    e.row = mdl_row;
                    e.idx = mdl_wr_idx;
                    q.push_back(e);
                    mdl_wr_idx++;
                end
                mdl_col++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rr) begin
            #1;
            row_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_px(input logic [7:0] v, input int unsigned gap_max);
        int unsigned g;
        logic done;
        g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (g) begin
            pix_valid = 1'b0;
            pix_in    = 8'($urandom);
            @(posedge clk); #1;
        end
        pix_valid = 1'b1;
        pix_in    = v;
        done      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            done = pix_ready;
            @(posedge clk); #1;
            if (done) break;
        end
        pix_valid = 1'b0;
        if (!done) chk("px_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_empty();
        logic empty;
        empty = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!empty) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic pulse_reset(input int unsigned n);
        rst       = 1'b0;
        pix_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b1;
    endtask

    initial begin
        int unsigned base_acc;
        int unsigned base_drn;

        // 1: reset
        pulse_reset(3);
        @(negedge clk);
        chk("t1_row_valid", row_valid, 1'b0);
        chk("t1_pix_ready", pix_ready, 1'b1);
        chk("t1_row_out", row_out, 64'h0);
        chk("t1_col_cnt", col_cnt, 3'd0);
        chk("t1_row_idx", row_idx, 3'd0);
        @(posedge clk); #1;

        // 2: one row, first-row latency and packing
        row_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_px(8'(8'h10 + i), 0);
        @(negedge clk);
        chk("t2_row_valid", row_valid, 1'b1);
        chk("t2_row_out", row_out, 64'h1716151413121110);
        chk("t2_row_idx", row_idx, 3'd0);
        @(posedge clk); #1;
        wait_empty();

        // 3: downstream stall fills both banks, then drains in order
        row_ready = 1'b0;
        base_acc  = accepted;
        base_drn  = drained;
        for (int i = 0; i < 16; i++) send_px(8'(8'h20 + i), 0);
        pix_valid = 1'b1;
        pix_in    = 8'h30;
        repeat (4) begin
            @(negedge clk);
            chk("t3_stall", pix_ready, 1'b0);
        end
        @(posedge clk); #1;
        row_ready = 1'b1;
        for (int i = 16; i < 24; i++) send_px(8'(8'h20 + i), 0);
        wait_empty();
        chk("t3_accepted", 64'(accepted - base_acc), 64'd24);
        chk("t3_drained", 64'(drained - base_drn), 64'd3);

        // 4: sustained rate over 9 rows from a fresh block
        pulse_reset(1);
        row_ready = 1'b1;
        t4_phase  = 1'b1;
        stall_cnt = 0;
        blk_cnt   = 0;
        base_drn  = drained;
        for (int i = 0; i < 72; i++) send_px(8'(i * 3 + 1), 0);
        wait_empty();
        t4_phase = 1'b0;
        chk("t4_stalls", 64'(stall_cnt), 64'd0);
        chk("t4_blk_last", 64'(blk_cnt), 64'd1);
        chk("t4_rows", 64'(drained - base_drn), 64'd9);
        chk("t4_next_idx", row_idx, 3'd1);

        // 5: reset mid-row discards the partial row
        for (int i = 0; i < 5; i++) send_px(8'(8'hE0 + i), 0);
        pulse_reset(1);
        @(negedge clk);
        chk("t5_col_cnt", col_cnt, 3'd0);
        chk("t5_row_idx", row_idx, 3'd0);
        @(posedge clk); #1;
        row_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_px(8'(8'hA0 + i), 0);
        @(negedge clk);
        chk("t5_row_out", row_out, 64'hA7A6A5A4A3A2A1A0);
        chk("t5_row_idx0", row_idx, 3'd0);
        @(posedge clk); #1;
        row_ready = 1'b1;
        wait_empty();

        // 6: random gaps on both sides
        base_acc = accepted;
        rand_rr  = 1'b1;
        for (int i = 0; i < 640; i++) send_px(8'($urandom), 3);
        rand_rr = 1'b0;
        @(posedge clk); #1;
        row_ready = 1'b1;
        wait_empty();
        chk("t6_accepted", 64'(accepted - base_acc), 64'd640);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
